// File: rtl/id_scoreboard.sv
// Register scoreboard for the decode stage.
// Tracks, per architectural register, the number of in-flight writers, the
// tag of the youngest writer and whether that writer's value is forwardable.
// ID may issue only while issue_ready is high.
// Optional feature: define SB_STALL_CNT_EN to build the stall-cycle counter;
// without it stall_cnt is tied to zero.
module id_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned NFWD  = 3,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [AW-1:0]         issue_dest,
  input  logic                  issue_fwd_now,
  output logic                  issue_ready,
  output logic [TAG_W-1:0]      issue_tag,
  input  logic [NSRC-1:0]       src_en,
  input  logic [NSRC*AW-1:0]    src_addr,
  output logic [NSRC-1:0]       src_ready,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD*AW-1:0]    fwd_dest,
  input  logic [NFWD*TAG_W-1:0] fwd_tag,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_dest,
  output logic [31:0]           stall_cnt
);

  logic [CNT_W-1:0] cnt_q  [NREG];
  logic [CNT_W-1:0] cnt_d  [NREG];
  logic [TAG_W-1:0] ytag_q [NREG];
  logic [TAG_W-1:0] ytag_d [NREG];
  logic [NREG-1:0]  avail_q;
  logic [NREG-1:0]  avail_d;
  logic [TAG_W-1:0] next_tag_q;
  logic             dest_full;
  logic             fire;

  // Source readiness: value is in the RF or the youngest writer can forward it
  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      src_ready[i] = !src_en[i]
                  || (src_addr[i*AW +: AW] == '0)
                  || (cnt_q[src_addr[i*AW +: AW]] == '0)
                  || avail_q[src_addr[i*AW +: AW]];
    end
  end

  // Issue gating: all sources ready and destination writer count not saturated
  always_comb begin
    dest_full   = issue_we && (issue_dest != '0) && (cnt_q[issue_dest] == '1);
    issue_ready = (&src_ready) && !dest_full;
    fire        = issue_valid && issue_ready && !flush;
    issue_tag   = next_tag_q;
  end

  // Per-register next state; priority is issue over retire over forward
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r]   = cnt_q[r];
      ytag_d[r]  = ytag_q[r];
      avail_d[r] = avail_q[r];
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      logic fwd_hit;
      logic issue_hit;
      logic wb_hit;
      fwd_hit = 1'b0;
      for (int unsigned j = 0; j < NFWD; j++) begin
        if (fwd_valid[j] && (fwd_dest[j*AW +: AW] == AW'(r))
            && (fwd_tag[j*TAG_W +: TAG_W] == ytag_q[r])) begin
          fwd_hit = 1'b1;
        end
      end
      issue_hit = fire && issue_we && (issue_dest == AW'(r));
      wb_hit    = wb_valid && (wb_dest == AW'(r));
      if (fwd_hit) begin
        avail_d[r] = 1'b1;
      end
      // A retire paired with an issue leaves the count unchanged
      if (wb_hit && !issue_hit && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
        if (cnt_q[r] == CNT_W'(1)) begin
          avail_d[r] = 1'b1;
        end
      end
      if (issue_hit) begin
        if (!wb_hit) begin
          cnt_d[r] = cnt_q[r] + 1'b1;
        end
        ytag_d[r]  = next_tag_q;
        avail_d[r] = issue_fwd_now;
      end
    end
  end

  // State register; flush clears pending writers but keeps the tag sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r]  <= '0;
        ytag_q[r] <= '0;
      end
      avail_q    <= '1;
      next_tag_q <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      avail_q <= '1;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r]  <= cnt_d[r];
        ytag_q[r] <= ytag_d[r];
      end
      avail_q <= avail_d;
      if (fire) begin
        next_tag_q <= next_tag_q + 1'b1;
      end
    end
  end

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where ID holds an instruction that cannot issue
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (issue_valid && !issue_ready && !flush) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // Retiring a register with no in-flight writer is a protocol error
  wb_underflow: assert property (@(posedge clk) disable iff (reset || flush)
    (wb_valid && (wb_dest != '0)) |-> (cnt_q[wb_dest] != '0));

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed vector table, hand-written
// reset/flush sequences and randomized traffic against a queue-based model.
module tb_id_scoreboard;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_dest;
  logic        issue_fwd_now;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic [1:0]  src_en;
  logic [9:0]  src_addr;
  logic [1:0]  src_ready;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_dest;
  logic [11:0] fwd_tag;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] stall_cnt;

  id_scoreboard #(
    .NREG(32), .AW(5), .NSRC(2), .NFWD(3), .CNT_W(2), .TAG_W(4)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
    .issue_fwd_now(issue_fwd_now), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .src_en(src_en), .src_addr(src_addr), .src_ready(src_ready),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_tag(fwd_tag),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per register, the ordered list of in-flight writer tags
  // (oldest first) and whether the youngest one is forwardable.
  int unsigned pend [32][$];
  bit          mfwd [32];
  int unsigned mtag;
  int unsigned mstall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_src_ok(input int i);
    int unsigned a;
    a = src_addr[i*5 +: 5];
    return !src_en[i] || a == 0 || pend[a].size() == 0 || mfwd[a];
  endfunction

  function automatic bit m_ready();
    bit ok;
    ok = m_src_ok(0) && m_src_ok(1);
    if (issue_we && issue_dest != 0 && pend[issue_dest].size() >= 3) ok = 0;
    return ok;
  endfunction

  function automatic int unsigned m_exp_stall();
`ifdef SB_STALL_CNT_EN
    return mstall;
`else
    return 0;
`endif
  endfunction

  function automatic int unsigned total_pending();
    int unsigned s;
    s = 0;
    for (int r = 0; r < 32; r++) s += pend[r].size();
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      pend[r].delete();
      mfwd[r] = 1;
    end
  endtask

  task automatic model_update();
    bit rdy;
    bit hit [32];
    int unsigned d;
    int unsigned t;
    if (reset) begin
      model_clear();
      mtag   = 0;
      mstall = 0;
      return;
    end
    rdy = m_ready();
    if (issue_valid && !rdy && !flush) mstall++;
    if (flush) begin
      model_clear();
      return;
    end
    for (int r = 0; r < 32; r++) hit[r] = 0;
    for (int j = 0; j < 3; j++) begin
      d = fwd_dest[j*5 +: 5];
      t = fwd_tag[j*4 +: 4];
      if (fwd_valid[j] && d != 0 && pend[d].size() > 0 && pend[d][$] == t) hit[d] = 1;
    end
    for (int r = 0; r < 32; r++) if (hit[r]) mfwd[r] = 1;
    if (wb_valid && wb_dest != 0 && pend[wb_dest].size() > 0) begin
      void'(pend[wb_dest].pop_front());
      if (pend[wb_dest].size() == 0) mfwd[wb_dest] = 1;
    end
    if (issue_valid && rdy) begin
      if (issue_we && issue_dest != 0) begin
        pend[issue_dest].push_back(mtag);
        mfwd[issue_dest] = issue_fwd_now;
      end
      mtag = (mtag + 1) % 16;
    end
  endtask

  task automatic model_check();
    check("issue_ready", issue_ready, m_ready());
    check("src_ready", src_ready, {m_src_ok(1), m_src_ok(0)});
    check("issue_tag", issue_tag, mtag);
    check("stall_cnt", stall_cnt, m_exp_stall());
  endtask

  // Inputs are driven just after negedge; compare, clock, then advance model
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; issue_valid = 0; issue_we = 0; issue_dest = 0; issue_fwd_now = 0;
    src_en = 0; src_addr = 0; fwd_valid = 0; fwd_dest = 0; fwd_tag = 0;
    wb_valid = 0; wb_dest = 0;
  endtask

  typedef struct {
    bit         iv, we;
    logic [4:0] dest;
    bit         fn;
    logic [1:0] sen;
    logic [4:0] s0, s1;
    bit         fv;
    logic [4:0] fd;
    logic [3:0] ft;
    bit         wb;
    logic [4:0] wd;
    bit         fl;
    bit         e_rdy;
    logic [1:0] e_src;
    logic [3:0] e_tag;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit iv, bit we, logic [4:0] dest, bit fn,
                             logic [1:0] sen, logic [4:0] s0, logic [4:0] s1,
                             bit fv, logic [4:0] fd, logic [3:0] ft,
                             bit wb, logic [4:0] wd, bit fl,
                             bit e_rdy, logic [1:0] e_src, logic [3:0] e_tag);
    vec_t x;
    x.iv = iv; x.we = we; x.dest = dest; x.fn = fn; x.sen = sen; x.s0 = s0; x.s1 = s1;
    x.fv = fv; x.fd = fd; x.ft = ft; x.wb = wb; x.wd = wd; x.fl = fl;
    x.e_rdy = e_rdy; x.e_src = e_src; x.e_tag = e_tag;
    return x;
  endfunction

  initial begin
    int unsigned r;
    int unsigned d;
    // fields: iv we dest fn | sen s0 s1 | fv fd ft | wb wd | fl || rdy src tag
    tbl.push_back(v(1,1,5,1, 0,0,0, 0,0,0, 0,0, 0, 1,3,0));  // reset state, issue r5
    tbl.push_back(v(0,0,0,0, 1,5,0, 0,0,0, 0,0, 0, 1,3,1));  // r5 forwardable
    tbl.push_back(v(1,0,0,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,1));
    tbl.push_back(v(1,0,0,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,2));
    tbl.push_back(v(1,1,7,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,3));  // load r7 tag 3
    tbl.push_back(v(1,0,0,0, 1,7,0, 0,0,0, 0,0, 0, 0,2,4));  // r7 blocks
    tbl.push_back(v(1,0,0,0, 1,7,0, 1,7,3, 0,0, 0, 0,2,4));  // fwd not bypassed
    tbl.push_back(v(1,0,0,0, 1,7,0, 0,0,0, 0,0, 0, 1,3,4));  // seen next cycle
    tbl.push_back(v(1,1,7,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,5));  // r7 tag 5
    tbl.push_back(v(1,1,7,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,6));  // r7 tag 6
    tbl.push_back(v(0,0,0,0, 1,7,0, 1,7,5, 0,0, 0, 0,2,7));  // stale tag
    tbl.push_back(v(0,0,0,0, 1,7,0, 1,7,6, 0,0, 0, 0,2,7));  // youngest tag
    tbl.push_back(v(0,0,0,0, 1,7,0, 0,0,0, 0,0, 0, 1,3,7));
    tbl.push_back(v(0,0,0,0, 1,7,0, 0,0,0, 1,7, 0, 1,3,7));
    tbl.push_back(v(0,0,0,0, 1,7,0, 0,0,0, 1,7, 0, 1,3,7));
    tbl.push_back(v(0,0,0,0, 1,7,0, 0,0,0, 1,7, 0, 1,3,7));
    tbl.push_back(v(1,1,9,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,7));  // r9 tag 7
    tbl.push_back(v(1,1,9,0, 0,0,0, 1,9,7, 1,9, 0, 1,3,8));  // issue+wb+old fwd
    tbl.push_back(v(0,0,0,0, 1,9,0, 0,0,0, 0,0, 0, 0,2,9));
    tbl.push_back(v(0,0,0,0, 1,9,0, 1,9,8, 0,0, 0, 0,2,9));
    tbl.push_back(v(0,0,0,0, 1,9,0, 0,0,0, 0,0, 0, 1,3,9));
    tbl.push_back(v(0,0,0,0, 1,9,0, 0,0,0, 1,9, 0, 1,3,9));
    tbl.push_back(v(1,1,4,1, 0,0,0, 0,0,0, 0,0, 0, 1,3,9));  // r4 x3
    tbl.push_back(v(1,1,4,1, 0,0,0, 0,0,0, 0,0, 0, 1,3,10));
    tbl.push_back(v(1,1,4,1, 0,0,0, 0,0,0, 0,0, 0, 1,3,11));
    tbl.push_back(v(1,1,4,1, 0,0,0, 0,0,0, 0,0, 0, 0,3,12)); // saturated
    tbl.push_back(v(1,1,4,1, 0,0,0, 0,0,0, 1,4, 0, 0,3,12)); // retire frees next cycle
    tbl.push_back(v(1,1,4,1, 0,0,0, 0,0,0, 0,0, 0, 1,3,12));
    tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 1,4, 0, 1,3,13));
    tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 1,4, 0, 1,3,13));
    tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 1,4, 0, 1,3,13));
    tbl.push_back(v(1,1,3,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,13)); // pending r3
    tbl.push_back(v(1,1,8,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,14)); // pending r8
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(1,0,0,0, 3,3,8, 0,0,0, 0,0, 0, 0,0,15));
    tbl.push_back(v(1,0,0,0, 3,3,8, 0,0,0, 0,0, 1, 0,0,15)); // flush
    tbl.push_back(v(0,0,0,0, 3,3,8, 0,0,0, 0,0, 0, 1,3,15)); // cleared
    tbl.push_back(v(1,1,15,1,0,0,0, 0,0,0, 0,0, 0, 1,3,15)); // tag wraps
    tbl.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0,0, 0, 1,3,0));  // r0 untracked
    tbl.push_back(v(0,0,0,0, 3,0,0, 0,0,0, 0,0, 0, 1,3,1));
    tbl.push_back(v(1,1,7,0, 1,7,0, 0,0,0, 0,0, 0, 1,3,1));  // r7 was drained
    tbl.push_back(v(0,0,0,0, 1,7,0, 0,0,0, 0,0, 0, 0,2,2));

    idle_inputs();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 0;

    // Directed table
    for (int k = 0; k < tbl.size(); k++) begin
      issue_valid = tbl[k].iv; issue_we = tbl[k].we; issue_dest = tbl[k].dest;
      issue_fwd_now = tbl[k].fn; src_en = tbl[k].sen; src_addr = {tbl[k].s1, tbl[k].s0};
      fwd_valid = {2'b00, tbl[k].fv}; fwd_dest = {10'd0, tbl[k].fd}; fwd_tag = {8'd0, tbl[k].ft};
      wb_valid = tbl[k].wb; wb_dest = tbl[k].wd; flush = tbl[k].fl;
      #1;
      check($sformatf("vec%0d_ready", k), issue_ready, tbl[k].e_rdy);
      check($sformatf("vec%0d_src", k), src_ready, tbl[k].e_src);
      check($sformatf("vec%0d_tag", k), issue_tag, tbl[k].e_tag);
      tick();
    end

    // Reset mid-operation (r7 still pending) returns to reset values
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    src_en = 2'b01; src_addr = 10'd7;
    #1;
    check("midreset_src", src_ready, 2'b11);
    check("midreset_tag", issue_tag, 4'd0);
    check("midreset_stall", stall_cnt, 32'd0);
    tick();

    // Five stalled cycles on r3, then flush
    idle_inputs();
    issue_valid = 1; issue_we = 1; issue_dest = 3;
    tick();
    idle_inputs();
    issue_valid = 1; src_en = 2'b01; src_addr = 10'd3;
    for (int k = 0; k < 5; k++) tick();
    flush = 1;
    tick();
    flush = 0; issue_valid = 0;
    #1;
    check("flush_src", src_ready, 2'b11);
    check("flush_tag", issue_tag, 4'd1);
`ifdef SB_STALL_CNT_EN
    check("flush_stall", stall_cnt, 32'd5);
`else
    check("flush_stall", stall_cnt, 32'd0);
`endif
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      idle_inputs();
      reset         = ($urandom_range(0, 399) == 0);
      flush         = ($urandom_range(0, 49) == 0);
      issue_valid   = ($urandom_range(0, 3) != 0);
      issue_we      = ($urandom_range(0, 3) != 0) && (total_pending() < 12);
      issue_dest    = 5'($urandom_range(0, 15));
      issue_fwd_now = $urandom_range(0, 1);
      src_en        = 2'($urandom_range(0, 3));
      src_addr      = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      for (int j = 0; j < 3; j++) begin
        d = $urandom_range(0, 15);
        fwd_valid[j] = $urandom_range(0, 1);
        fwd_dest[j*5 +: 5] = 5'(d);
        if (pend[d].size() > 0 && $urandom_range(0, 1) == 1)
          fwd_tag[j*4 +: 4] = 4'(pend[d][$]);
        else
          fwd_tag[j*4 +: 4] = 4'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 15);
      wb_dest  = 5'(r);
      wb_valid = ($urandom_range(0, 2) == 0) && (r == 0 || pend[r].size() > 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
